// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - default Galois tap masks and matching nonzero seeds
package lfsr_pkg;

  // x^4 + x + 1, maximal length 15
  localparam logic [3:0]  LFSR4_TAPS  = 4'b0010;
  localparam logic [3:0]  LFSR4_SEED  = 4'b0001;

  localparam logic [25:0] LFSR26_TAPS = 26'h0000182;
  localparam logic [25:0] LFSR26_SEED = 26'h0000001;

endpackage

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - combinational STEP-fold Galois LFSR advance with emitted bits
module lfsr_step #(
  parameter int          WIDTH = 26,
  parameter logic [WIDTH-1:0] TAPS = 26'h0000182,
  parameter int          STEP  = 1
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] next_o,
  output logic [STEP-1:0]  bits_o
);

  // Bit 0 is always fed by the shift itself, so its tap bit is masked off
  localparam logic [WIDTH-1:0] TAP_MASK = {TAPS[WIDTH-1:1], 1'b0};

  logic [WIDTH-1:0] chain [0:STEP];

  assign chain[0] = state_i;

  for (genvar k = 0; k < STEP; k++) begin : g_step
    logic fb;
    assign fb              = chain[k][WIDTH-1];
    assign chain[k+1]      = {chain[k][WIDTH-2:0], fb} ^ (TAP_MASK & {WIDTH{fb}});
    assign bits_o[STEP-1-k] = fb;
  end

  assign next_o = chain[STEP];

endmodule

// File: rtl/lfsr_prbs_gen.sv
// rtl/lfsr_prbs_gen.sv - Galois LFSR/PRBS stream generator; LFSR_LOCKUP_RECOVER_EN enables zero-state recovery
module lfsr_prbs_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 26,
  parameter logic [WIDTH-1:0] TAPS  = LFSR26_TAPS,
  parameter logic [WIDTH-1:0] SEED  = LFSR26_SEED,
  parameter int               STEP  = 1,
  parameter int               CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [STEP-1:0]  out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] state,
  output logic             lockup,
  output logic             wrap,
  output logic [CNT_W-1:0] adv_cnt
);

  logic [WIDTH-1:0] state_q, state_d, step_next;
  logic [STEP-1:0]  data_q, step_bits;
  logic             valid_q, wrap_q;
  logic [CNT_W-1:0] cnt_q;
  logic             adv;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEP  (STEP)
  ) u_step (
    .state_i (state_q),
    .next_o  (step_next),
    .bits_o  (step_bits)
  );

  assign lockup = (state_q == '0);
  // Backpressure stalls the state so no emitted bit is ever dropped
  assign adv    = en & (~valid_q | out_ready);

`ifdef LFSR_LOCKUP_RECOVER_EN
  assign state_d = lockup ? SEED : step_next;
`else
  assign state_d = step_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
      data_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (load) begin
      state_q <= din;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (adv) begin
      state_q <= state_d;
      data_q  <= step_bits;
      valid_q <= 1'b1;
      wrap_q  <= (state_d == SEED);
      cnt_q   <= cnt_q + CNT_W'(1);
    end else begin
      wrap_q <= 1'b0;
      if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign state     = state_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign wrap      = wrap_q;
  assign adv_cnt   = cnt_q;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// tb/tb_lfsr_prbs_gen.sv - directed vector bench for lfsr_prbs_gen (STEP=1 and STEP=4 instances)
module tb_lfsr_prbs_gen;

  logic       clk = 1'b0;
  logic       rst, en, load, out_ready;
  logic [3:0] din;

  logic [0:0] d1;
  logic       v1, lk1, w1;
  logic [3:0] s1, c1;

  logic [3:0] d4;
  logic       v4, lk4, w4;
  logic [3:0] s4;
  logic [7:0] c4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lfsr_prbs_gen #(
    .WIDTH (4), .TAPS (4'b0010), .SEED (4'b0001), .STEP (1), .CNT_W (4)
  ) u1 (
    .clk (clk), .rst (rst), .en (en), .load (load), .din (din),
    .out_data (d1), .out_valid (v1), .out_ready (out_ready),
    .state (s1), .lockup (lk1), .wrap (w1), .adv_cnt (c1)
  );

  lfsr_prbs_gen #(
    .WIDTH (4), .TAPS (4'b0010), .SEED (4'b0001), .STEP (4), .CNT_W (8)
  ) u4 (
    .clk (clk), .rst (rst), .en (en), .load (load), .din (din),
    .out_data (d4), .out_valid (v4), .out_ready (out_ready),
    .state (s4), .lockup (lk4), .wrap (w4), .adv_cnt (c4)
  );

  typedef struct {
    logic       en;
    logic       rdy;
    logic [3:0] st;
    logic       d;
    logic       v;
    logic       w;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_st [15];
    logic       exp_bit [15];
    int         wraps;

    exp_st  = '{4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0110, 4'b1100, 4'b1011, 4'b0101,
                4'b1010, 4'b0111, 4'b1110, 4'b1111, 4'b1101, 4'b1001, 4'b0001};
    exp_bit = '{0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 1};
    for (int i = 0; i < 15; i++) begin
      tbl[i].en  = 1'b1;
      tbl[i].rdy = 1'b1;
      tbl[i].st  = exp_st[i];
      tbl[i].d   = exp_bit[i];
      tbl[i].v   = 1'b1;
      tbl[i].w   = (i == 14);
      tbl[i].cnt = 4'(i + 1);
    end

    rst = 1'b1; en = 1'b1; load = 1'b0; din = 4'b0; out_ready = 1'b1;
    tick; tick;
    chk("rst_state", 32'(s1), 32'h1);
    chk("rst_valid", 32'(v1), 32'h0);
    chk("rst_data",  32'(d1), 32'h0);
    chk("rst_wrap",  32'(w1), 32'h0);
    chk("rst_cnt",   32'(c1), 32'h0);
    chk("rst_lockup", 32'(lk1), 32'h0);

    // Full period, one bit per cycle
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      en = tbl[i].en; out_ready = tbl[i].rdy;
      tick;
      chk($sformatf("seq_state[%0d]", i), 32'(s1), 32'(tbl[i].st));
      chk($sformatf("seq_data[%0d]", i),  32'(d1), 32'(tbl[i].d));
      chk($sformatf("seq_valid[%0d]", i), 32'(v1), 32'(tbl[i].v));
      chk($sformatf("seq_wrap[%0d]", i),  32'(w1), 32'(tbl[i].w));
      chk($sformatf("seq_cnt[%0d]", i),   32'(c1), 32'(tbl[i].cnt));
    end
    tick;
    chk("cnt_wrap_zero", 32'(c1), 32'h0);
    chk("cnt_wrap_state", 32'(s1), 32'h2);
    chk("wrap_one_cycle", 32'(w1), 32'h0);

    // Backpressure: stall after the third advance, then resume
    rst = 1'b1; tick; rst = 1'b0;
    tick; tick; tick;
    chk("bp_pre_state", 32'(s1), 32'h8);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("bp_valid[%0d]", i), 32'(v1), 32'h1);
      chk($sformatf("bp_state[%0d]", i), 32'(s1), 32'h8);
      chk($sformatf("bp_data[%0d]", i),  32'(d1), 32'h0);
    end
    out_ready = 1'b1;
    tick;
    chk("bp_resume_state", 32'(s1), 32'h3);
    chk("bp_resume_data",  32'(d1), 32'h1);
    tick;
    chk("bp_resume2_state", 32'(s1), 32'h6);
    chk("bp_resume2_data",  32'(d1), 32'h0);

    // Load wins over a same-cycle enable
    load = 1'b1; din = 4'b1000; en = 1'b1;
    tick;
    load = 1'b0;
    chk("load_state", 32'(s1), 32'h8);
    chk("load_valid", 32'(v1), 32'h0);
    chk("load_cnt",   32'(c1), 32'h0);
    tick;
    chk("load_next_state", 32'(s1), 32'h3);
    chk("load_next_data",  32'(d1), 32'h1);
    chk("load_next_cnt",   32'(c1), 32'h1);

    // Zero-state lockup
    en = 1'b0; load = 1'b1; din = 4'b0000;
    tick;
    load = 1'b0;
    chk("lk_state", 32'(s1), 32'h0);
    chk("lk_flag",  32'(lk1), 32'h1);
    en = 1'b1;
    tick;
    chk("lk_adv_data", 32'(d1), 32'h0);
`ifdef LFSR_LOCKUP_RECOVER_EN
    chk("lk_recover_state", 32'(s1), 32'h1);
    chk("lk_recover_flag",  32'(lk1), 32'h0);
`else
    chk("lk_stuck_state", 32'(s1), 32'h0);
    chk("lk_stuck_flag",  32'(lk1), 32'h1);
    tick;
    chk("lk_stuck_state2", 32'(s1), 32'h0);
    chk("lk_stuck_data2",  32'(d1), 32'h0);
`endif

    // Reset mid-stream while a word is pending
    rst = 1'b1; tick; rst = 1'b0;
    en = 1'b1; out_ready = 1'b1;
    tick; tick;
    out_ready = 1'b0;
    tick;
    chk("mid_pre_valid", 32'(v1), 32'h1);
    rst = 1'b1;
    tick;
    chk("mid_rst_state", 32'(s1), 32'h1);
    chk("mid_rst_valid", 32'(v1), 32'h0);
    chk("mid_rst_cnt",   32'(c1), 32'h0);
    chk("mid_rst_wrap",  32'(w1), 32'h0);

    // STEP=4: 15 words cover four full periods, so wrap fires only on the last
    rst = 1'b0; out_ready = 1'b1; en = 1'b1;
    wraps = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (w4) wraps++;
      if (i == 0) begin
        chk("s4_word1_data",  32'(d4), 32'h1);
        chk("s4_word1_state", 32'(s4), 32'h3);
        chk("s4_word1_valid", 32'(v4), 32'h1);
      end
      if (i == 1) chk("s4_word2_data", 32'(d4), 32'h3);
      if (i == 3) chk("s4_word4_data", 32'(d4), 32'hE);
    end
    chk("s4_wrap_last",  32'(w4), 32'h1);
    chk("s4_wrap_count", 32'(wraps), 32'h1);
    chk("s4_state_15",   32'(s4), 32'h1);
    chk("s4_cnt_15",     32'(c4), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
